// File: rtl/adder_pkg.sv
// Package adder_pkg
// Shared types and helpers for the multi-cycle chunked adder.
//   adder_state_e : FSM encoding (IDLE, RUN, DONE)
//   chunk_count() : number of CHUNK-bit slices in a WIDTH-bit operand
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_e;

  function automatic int chunk_count(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Module chunk_ripple_adder
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Ports:
//   x, y      in  CHUNK  operand slices
//   carryin   in  1      carry into bit 0
//   sum       out CHUNK  slice sum
//   carryout  out 1      carry out of bit CHUNK-1
module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             carryin,
  output logic [CHUNK-1:0] sum,
  output logic             carryout
);

  // The carry is a procedural variable so the ripple is expressed as a chain
  // of full-adder cells without a self-referencing carry vector.
  always_comb begin
    logic c;
    // NOTE: every output of an always_comb gets a default before any
    // conditional or looped assignment, so no latch can be inferred.
    sum = '0;
    c   = carryin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    carryout = c;
  end

endmodule

// File: rtl/multicycle_chunk_adder.sv
// Module multicycle_chunk_adder
// Sequential WIDTH-bit adder that adds CHUNK bits per clock, LSB chunk first,
// holding the inter-chunk carry in a register. Valid/ready on both sides.
// Optional feature macro: ADDER_SUB_EN (adds the 'sub' port, x - y).
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands presented
//   in_ready   out  1      operands can be accepted (registered)
//   x, y       in   WIDTH  operands, sampled on accept
//   cin        in   1      carry-in, sampled on accept
//   sub        in   1      (ADDER_SUB_EN only) 1 = x - y, sampled on accept
//   out_valid  out  1      result valid (registered)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of the MSB chunk
//   busy       out  1      high in RUN or DONE
module multicycle_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("multicycle_chunk_adder: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  adder_state_e     state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             carry, carry_next;
  logic             in_ready_next, out_valid_next, cout_next;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] x_q, y_q;

  logic             accept;
  logic [WIDTH-1:0] op_y;
  logic             op_cin;
  logic [CHUNK-1:0] x_chunk, y_chunk, chunk_sum;
  logic             chunk_carry;

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign busy   = (state != IDLE);

  // Subtraction is x + ~y + 1: the operand is inverted once at accept time so
  // the datapath below is identical for add and subtract.
`ifdef ADDER_SUB_EN
  assign op_y   = sub ? ~y : y;
  assign op_cin = sub ? 1'b1 : cin;
`else
  assign op_y   = y;
  assign op_cin = cin;
`endif

  assign x_chunk = x_q[idx*CHUNK +: CHUNK];
  assign y_chunk = y_q[idx*CHUNK +: CHUNK];

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .x        (x_chunk),
    .y        (y_chunk),
    .carryin  (carry),
    .sum      (chunk_sum),
    .carryout (chunk_carry)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    carry_next     = carry;
    in_ready_next  = in_ready;
    out_valid_next = out_valid;
    cout_next      = cout;
    sum_next       = sum;

    unique case (state)
      IDLE: begin
        in_ready_next = 1'b1;
        if (accept) begin
          in_ready_next = 1'b0;
          idx_next      = '0;
          carry_next    = op_cin;
          state_next    = RUN;
        end
      end

      RUN: begin
        sum_next[idx*CHUNK +: CHUNK] = chunk_sum;
        carry_next = chunk_carry;
        if (idx == LAST_IDX) begin
          cout_next  = chunk_carry;
          idx_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx + 1'b1;
        end
      end

      DONE: begin
        // out_valid is raised one cycle after the last chunk lands, so the
        // result is on sum/cout for a full cycle before it is advertised.
        if (out_valid && out_ready) begin
          out_valid_next = 1'b0;
          in_ready_next  = 1'b1;
          state_next     = IDLE;
        end else begin
          out_valid_next = 1'b1;
        end
      end

      default: begin
        state_next     = IDLE;
        in_ready_next  = 1'b0;
        out_valid_next = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      cout      <= 1'b0;
      sum       <= '0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      carry     <= carry_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      cout      <= cout_next;
      sum       <= sum_next;
    end
  end

  // NOTE: operand registers are pure datapath, only read after an accept has
  // loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q <= x;
      y_q <= op_y;
    end
  end

endmodule
